// File: rtl/opl3_pkg.sv
// Shared definitions for the OPL3 timer/status host logic.
//   - REG_TIMER_WIDTH         : width of the timer reload registers
//   - ADDR_*                  : bank-0 register addresses decoded by the block
//   - CTRL_*                  : bit positions inside the timer control register 0x04
//   - status_t                : layout of the status byte returned to the host
package opl3_pkg;

  localparam int unsigned REG_TIMER_WIDTH = 8;

  localparam logic [7:0] ADDR_TIMER1     = 8'h02;
  localparam logic [7:0] ADDR_TIMER2     = 8'h03;
  localparam logic [7:0] ADDR_TIMER_CTRL = 8'h04;

  localparam int unsigned CTRL_IRQ_RST = 7;
  localparam int unsigned CTRL_MASK_T1 = 6;
  localparam int unsigned CTRL_MASK_T2 = 5;
  localparam int unsigned CTRL_ST2     = 1;
  localparam int unsigned CTRL_ST1     = 0;

  typedef struct packed {
    logic       irq;
    logic       ft1;
    logic       ft2;
    logic [4:0] rsvd;
  } status_t;

endpackage

// File: rtl/opl3_timer_flag.sv
// One timer status flag (FT1 or FT2).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   set          : overflow pulse from the timer
//   mask         : when high, overflow pulses are dropped
//   clr          : flag clear request (IRQ-RST or clear-on-read)
//   flag         : registered flag value
// An unmasked set wins over a clear in the same cycle so no overflow is lost.
module opl3_timer_flag (
  input  logic clk,
  input  logic reset_n,
  input  logic set,
  input  logic mask,
  input  logic clr,
  output logic flag
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag <= 1'b0;
    end else if (set && !mask) begin
      flag <= 1'b1;
    end else if (clr) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/opl3_timer_status.sv
// Host-side register decode and status logic for the two OPL3 interval timers.
// Decodes bank-0 writes to 0x02/0x03/0x04 into reload values, run enables and
// mask bits; latches FT1/FT2 from the timer overflow pulses; drives the
// active-low IRQ pin and answers status reads through a req/valid handshake.
//
// Ports:
//   clk, reset_n                        : clock, asynchronous active-low reset
//   reg_wr_en/bank/addr/data            : one-cycle register write
//   timer1/2_overflow_pulse             : overflow pulses from the timers
//   timer1/2_reg                        : timer reload values (level)
//   start_timer1/2                      : timer run enables (level)
//   status_rd_req                       : one-cycle status read request
//   status_rd_valid, status_rd_data     : response strobe and {IRQ,FT1,FT2,5'b0}
//   irq_n                               : registered active-low interrupt
//
// Build option: define OPL3_STATUS_CLEAR_ON_READ_EN to make a status read clear
// FT1/FT2 (the read still returns the pre-clear value). Undefined, reads have
// no side effects and flags clear only through IRQ-RST.
module opl3_timer_status
  import opl3_pkg::*;
#(
  parameter int unsigned STATUS_RD_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       reg_wr_en,
  input  logic                       reg_wr_bank,
  input  logic [7:0]                 reg_wr_addr,
  input  logic [7:0]                 reg_wr_data,
  input  logic                       timer1_overflow_pulse,
  input  logic                       timer2_overflow_pulse,
  output logic [REG_TIMER_WIDTH-1:0] timer1_reg,
  output logic [REG_TIMER_WIDTH-1:0] timer2_reg,
  output logic                       start_timer1,
  output logic                       start_timer2,
  input  logic                       status_rd_req,
  output logic                       status_rd_valid,
  output logic [7:0]                 status_rd_data,
  output logic                       irq_n
);

  // Only a single-cycle read response is implemented.
  if (STATUS_RD_LATENCY != 1) begin : g_bad_latency
    $fatal(1, "opl3_timer_status: STATUS_RD_LATENCY must be 1");
  end

  logic    wr_hit;
  logic    wr_ctrl;
  logic    irq_rst;
  logic    ctrl_upd;
  logic    rd_clr;
  logic    flag_clr;
  logic    mask_t1;
  logic    mask_t2;
  logic    ft1;
  logic    ft2;
  status_t status_now;

  // Write decode: bank 0 only.
  always_comb begin
    wr_hit   = reg_wr_en && !reg_wr_bank;
    wr_ctrl  = wr_hit && (reg_wr_addr == ADDR_TIMER_CTRL);
    irq_rst  = wr_ctrl && reg_wr_data[CTRL_IRQ_RST];
    ctrl_upd = wr_ctrl && !reg_wr_data[CTRL_IRQ_RST];
  end

`ifdef OPL3_STATUS_CLEAR_ON_READ_EN
  assign rd_clr = status_rd_req;
`else
  assign rd_clr = 1'b0;
`endif

  assign flag_clr = irq_rst || rd_clr;

  // Reload values, run enables and masks. IRQ-RST leaves them untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer1_reg   <= '0;
      timer2_reg   <= '0;
      start_timer1 <= 1'b0;
      start_timer2 <= 1'b0;
      mask_t1      <= 1'b0;
      mask_t2      <= 1'b0;
    end else begin
      if (wr_hit && (reg_wr_addr == ADDR_TIMER1)) begin
        timer1_reg <= REG_TIMER_WIDTH'(reg_wr_data);
      end
      if (wr_hit && (reg_wr_addr == ADDR_TIMER2)) begin
        timer2_reg <= REG_TIMER_WIDTH'(reg_wr_data);
      end
      if (ctrl_upd) begin
        mask_t1      <= reg_wr_data[CTRL_MASK_T1];
        mask_t2      <= reg_wr_data[CTRL_MASK_T2];
        start_timer1 <= reg_wr_data[CTRL_ST1];
        start_timer2 <= reg_wr_data[CTRL_ST2];
      end
    end
  end

  opl3_timer_flag u_flag_t1 (
    .clk     (clk),
    .reset_n (reset_n),
    .set     (timer1_overflow_pulse),
    .mask    (mask_t1),
    .clr     (flag_clr),
    .flag    (ft1)
  );

  opl3_timer_flag u_flag_t2 (
    .clk     (clk),
    .reset_n (reset_n),
    .set     (timer2_overflow_pulse),
    .mask    (mask_t2),
    .clr     (flag_clr),
    .flag    (ft2)
  );

  // Status byte as it stands this cycle.
  always_comb begin
    status_now      = '0;
    status_now.irq  = ft1 || ft2;
    status_now.ft1  = ft1;
    status_now.ft2  = ft2;
  end

  // Read response and interrupt pin; read data holds between requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_rd_valid <= 1'b0;
      status_rd_data  <= '0;
      irq_n           <= 1'b1;
    end else begin
      status_rd_valid <= status_rd_req;
      if (status_rd_req) begin
        status_rd_data <= status_now;
      end
      irq_n <= !(ft1 || ft2);
    end
  end

endmodule

// File: tb/tb_opl3_timer_status.sv
// Directed testbench for opl3_timer_status. Inputs change on the falling edge,
// outputs are checked on the falling edge after the rising edge that updates them.
module tb_opl3_timer_status;

  logic       clk;
  logic       reset_n;
  logic       reg_wr_en;
  logic       reg_wr_bank;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       timer1_overflow_pulse;
  logic       timer2_overflow_pulse;
  logic [7:0] timer1_reg;
  logic [7:0] timer2_reg;
  logic       start_timer1;
  logic       start_timer2;
  logic       status_rd_req;
  logic       status_rd_valid;
  logic [7:0] status_rd_data;
  logic       irq_n;

  int n_checks;
  int n_fail;

`ifdef OPL3_STATUS_CLEAR_ON_READ_EN
  localparam logic [7:0] EXP_RD2 = 8'h00;
`else
  localparam logic [7:0] EXP_RD2 = 8'hA0;
`endif

  opl3_timer_status #(.STATUS_RD_LATENCY(1)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .reg_wr_en             (reg_wr_en),
    .reg_wr_bank           (reg_wr_bank),
    .reg_wr_addr           (reg_wr_addr),
    .reg_wr_data           (reg_wr_data),
    .timer1_overflow_pulse (timer1_overflow_pulse),
    .timer2_overflow_pulse (timer2_overflow_pulse),
    .timer1_reg            (timer1_reg),
    .timer2_reg            (timer2_reg),
    .start_timer1          (start_timer1),
    .start_timer2          (start_timer2),
    .status_rd_req         (status_rd_req),
    .status_rd_valid       (status_rd_valid),
    .status_rd_data        (status_rd_data),
    .irq_n                 (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic bank, input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    reg_wr_en   = 1'b1;
    reg_wr_bank = bank;
    reg_wr_addr = addr;
    reg_wr_data = data;
    @(negedge clk);
    reg_wr_en   = 1'b0;
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 1) timer1_overflow_pulse = 1'b1;
    else            timer2_overflow_pulse = 1'b1;
    @(negedge clk);
    timer1_overflow_pulse = 1'b0;
    timer2_overflow_pulse = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    status_rd_req = 1'b1;
    @(negedge clk);
    status_rd_req = 1'b0;
    chk({tag, "_valid"}, 32'(status_rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(status_rd_data), 32'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n = 1'b0;
    reg_wr_en = 1'b0; reg_wr_bank = 1'b0; reg_wr_addr = 8'h00; reg_wr_data = 8'h00;
    timer1_overflow_pulse = 1'b0; timer2_overflow_pulse = 1'b0;
    status_rd_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_t1reg", 32'(timer1_reg), 32'h0);
    chk("rst_t2reg", 32'(timer2_reg), 32'h0);
    chk("rst_starts", 32'({start_timer1, start_timer2}), 32'h0);
    chk("rst_valid", 32'(status_rd_valid), 32'h0);
    chk("rst_data", 32'(status_rd_data), 32'h0);
    chk("rst_irqn", 32'(irq_n), 32'h1);
    reset_n = 1'b1;

    // Reload and start programming
    wr(1'b0, 8'h02, 8'hF0);
    chk("t1reg_next_cycle", 32'(timer1_reg), 32'hF0);
    wr(1'b0, 8'h03, 8'h80);
    wr(1'b0, 8'h04, 8'h03);
    chk("t2reg", 32'(timer2_reg), 32'h80);
    chk("starts_on", 32'({start_timer1, start_timer2}), 32'h3);
    chk("irqn_idle", 32'(irq_n), 32'h1);
    wr(1'b1, 8'h02, 8'h55);
    wr(1'b0, 8'h05, 8'h55);
    chk("bank1_ignored", 32'(timer1_reg), 32'hF0);
    chk("addr05_ignored", 32'(timer2_reg), 32'h80);
    wr(1'b0, 8'h04, 8'h03);
    chk("start_rewrite", 32'({start_timer1, start_timer2}), 32'h3);

    // Timer 1 overflow, unmasked
    pulse(1);
    chk("irqn_n1", 32'(irq_n), 32'h1);
    @(negedge clk);
    chk("irqn_n2", 32'(irq_n), 32'h0);
    rd_chk("rd_ft1", 8'hC0);
    wr(1'b0, 8'h04, 8'h80);
    repeat (2) @(negedge clk);
    chk("irqn_after_rst1", 32'(irq_n), 32'h1);
    rd_chk("rd_cleared1", 8'h00);
    chk("starts_kept_irqrst", 32'({start_timer1, start_timer2}), 32'h3);

    // Masked timer 1 overflow is dropped permanently
    wr(1'b0, 8'h04, 8'h40);
    chk("starts_off", 32'({start_timer1, start_timer2}), 32'h0);
    pulse(1);
    repeat (2) @(negedge clk);
    chk("irqn_masked", 32'(irq_n), 32'h1);
    rd_chk("rd_masked", 8'h00);
    wr(1'b0, 8'h04, 8'h03);
    rd_chk("rd_unmasked_dropped", 8'h00);

    // FT2 set, then IRQ-RST coincident with another timer 2 pulse
    pulse(2);
    @(negedge clk);
    reg_wr_en = 1'b1; reg_wr_bank = 1'b0; reg_wr_addr = 8'h04; reg_wr_data = 8'h80;
    timer2_overflow_pulse = 1'b1;
    @(negedge clk);
    reg_wr_en = 1'b0;
    timer2_overflow_pulse = 1'b0;

    // Three back-to-back reads
    status_rd_req = 1'b1;
    @(negedge clk);
    chk("b2b1_valid", 32'(status_rd_valid), 32'd1);
    chk("b2b1_data", 32'(status_rd_data), 32'hA0);
    @(negedge clk);
    chk("b2b2_valid", 32'(status_rd_valid), 32'd1);
    chk("b2b2_data", 32'(status_rd_data), 32'(EXP_RD2));
    @(negedge clk);
    status_rd_req = 1'b0;
    chk("b2b3_valid", 32'(status_rd_valid), 32'd1);
    chk("b2b3_data", 32'(status_rd_data), 32'(EXP_RD2));
    @(negedge clk);
    chk("b2b_end_valid", 32'(status_rd_valid), 32'd0);
    chk("rd_data_hold", 32'(status_rd_data), 32'(EXP_RD2));

    // Standalone IRQ-RST: irq_n deasserts two cycles after the write
    pulse(2);
    @(negedge clk);
    chk("irqn_ft2", 32'(irq_n), 32'h0);
    wr(1'b0, 8'h04, 8'h80);
    chk("irqn_rst_plus1", 32'(irq_n), 32'h0);
    @(negedge clk);
    chk("irqn_rst_plus2", 32'(irq_n), 32'h1);
    rd_chk("rd_cleared2", 8'h00);

    // Asynchronous reset during a read with a flag set
    pulse(1);
    @(negedge clk);
    status_rd_req = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_arst_valid", 32'(status_rd_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(status_rd_valid), 32'd0);
    chk("arst_data", 32'(status_rd_data), 32'h0);
    chk("arst_regs", 32'({timer1_reg, timer2_reg}), 32'h0);
    chk("arst_starts", 32'({start_timer1, start_timer2}), 32'h0);
    chk("arst_irqn", 32'(irq_n), 32'h1);
    @(negedge clk);
    status_rd_req = 1'b0;
    reset_n = 1'b1;
    rd_chk("rd_after_arst", 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
